// File: rtl/mem_stage.sv
// Memory stage: data-memory access, architectural flag register, branch/jump
// resolution toward fetch, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int PC_WIDTH  = 32,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_AW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_mem_write_enable,
    input  logic                in_sel_beq_bne,
    input  logic                in_fl_write_enable,
    input  logic                in_sel_jt_jf,
    input  logic                in_sel_jflag_branch,
    input  logic                in_is_branch,
    input  logic                in_is_jump,
    input  logic [1:0]          in_wb_res_mux,
    input  logic                in_reg_write_enable,
    input  logic [PC_WIDTH-1:0] in_next_pc,
    input  logic [31:0]         in_immediate,
    input  logic [31:0]         in_abs_addr,
    input  logic [31:0]         in_mem_addr,
    input  logic [31:0]         in_mem_data,
    input  logic [31:0]         in_alu_out,
    input  logic [5:0]          in_alu_flags,
    input  logic [4:0]          in_flag_addr,
    input  logic [4:0]          in_reg_dst,
    output logic                branch_taken,
    output logic [PC_WIDTH-1:0] branch_target,
    output logic [5:0]          flag_reg,
    output logic                wb_reg_write_enable,
    output logic [1:0]          wb_res_mux,
    output logic [31:0]         wb_alu_out,
    output logic [31:0]         wb_mem_data,
    output logic [PC_WIDTH-1:0] wb_next_pc,
    output logic [31:0]         wb_immediate,
    output logic [4:0]          wb_reg_dst
);

    // Indices beyond the six implemented flags read as zero.
    function automatic logic flag_lookup(input logic [5:0] flags, input logic [4:0] idx);
        logic bit_s;
        case (idx)
            5'd0:    bit_s = flags[0];
            5'd1:    bit_s = flags[1];
            5'd2:    bit_s = flags[2];
            5'd3:    bit_s = flags[3];
            5'd4:    bit_s = flags[4];
            5'd5:    bit_s = flags[5];
            default: bit_s = 1'b0;
        endcase
        return bit_s;
    endfunction

    logic [31:0]         mem_r [MEM_DEPTH];
    logic [MEM_AW-1:0]   addr_s;
    logic                valid_s;
    logic                sel_flag_s;
    logic                br_s;
    logic                jp_s;
    logic                unused_addr_s;

    logic [5:0]          flag_r;
    logic                wb_reg_write_enable_r;
    logic [1:0]          wb_res_mux_r;
    logic [31:0]         wb_alu_out_r;
    logic [31:0]         wb_mem_data_r;
    logic [PC_WIDTH-1:0] wb_next_pc_r;
    logic [31:0]         wb_immediate_r;
    logic [4:0]          wb_reg_dst_r;

    assign addr_s        = in_mem_addr[MEM_AW-1:0];
    assign valid_s       = ~flush & ~stall & ~rst;
    assign unused_addr_s = ^in_mem_addr[31:MEM_AW];

    // Branch/jump decision; flag lookup uses the pre-write flag register.
    always_comb begin
        sel_flag_s   = 1'b0;
        br_s         = 1'b0;
        jp_s         = 1'b0;
        branch_taken = 1'b0;
        sel_flag_s   = flag_lookup(flag_r, in_flag_addr);
        br_s         = in_is_branch & (in_alu_flags[0] ^ in_sel_beq_bne);
        jp_s         = in_is_jump & (~in_sel_jflag_branch | (sel_flag_s == in_sel_jt_jf));
        branch_taken = (br_s | jp_s) & ~flush & ~rst;
    end

    // Redirect target: jumps are absolute and win over PC-relative branches.
    always_comb begin
        branch_target = {PC_WIDTH{1'b0}};
        if (in_is_jump) begin
            branch_target = in_abs_addr[PC_WIDTH-1:0];
        end else begin
            branch_target = in_next_pc + in_immediate[PC_WIDTH-1:0];
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (valid_s && in_mem_write_enable) begin
            mem_r[addr_s] <= in_mem_data;
        end
    end

    // Flag register and MEM/WB bundle; the memory read sees pre-store data.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_r                <= 6'd0;
            wb_reg_write_enable_r <= 1'b0;
            wb_res_mux_r          <= 2'd0;
            wb_alu_out_r          <= 32'd0;
            wb_mem_data_r         <= 32'd0;
            wb_next_pc_r          <= {PC_WIDTH{1'b0}};
            wb_immediate_r        <= 32'd0;
            wb_reg_dst_r          <= 5'd0;
        end else if (!stall) begin
            if (!flush && in_fl_write_enable) begin
                flag_r <= in_alu_flags;
            end
            wb_reg_write_enable_r <= in_reg_write_enable & ~flush;
            wb_res_mux_r          <= in_wb_res_mux;
            wb_alu_out_r          <= in_alu_out;
            wb_mem_data_r         <= mem_r[addr_s];
            wb_next_pc_r          <= in_next_pc;
            wb_immediate_r        <= in_immediate;
            wb_reg_dst_r          <= in_reg_dst;
        end
    end

    assign flag_reg            = flag_r;
    assign wb_reg_write_enable = wb_reg_write_enable_r;
    assign wb_res_mux          = wb_res_mux_r;
    assign wb_alu_out          = wb_alu_out_r;
    assign wb_mem_data         = wb_mem_data_r;
    assign wb_next_pc          = wb_next_pc_r;
    assign wb_immediate        = wb_immediate_r;
    assign wb_reg_dst          = wb_reg_dst_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, hand-written sequences
// and randomized traffic against a behavioural model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_mem_write_enable, in_sel_beq_bne, in_fl_write_enable;
    logic        in_sel_jt_jf, in_sel_jflag_branch, in_is_branch, in_is_jump;
    logic [1:0]  in_wb_res_mux;
    logic        in_reg_write_enable;
    logic [31:0] in_next_pc, in_immediate, in_abs_addr, in_mem_addr, in_mem_data, in_alu_out;
    logic [5:0]  in_alu_flags;
    logic [4:0]  in_flag_addr, in_reg_dst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [5:0]  flag_reg;
    logic        wb_reg_write_enable;
    logic [1:0]  wb_res_mux;
    logic [31:0] wb_alu_out, wb_mem_data, wb_next_pc, wb_immediate;
    logic [4:0]  wb_reg_dst;

    mem_stage #(.PC_WIDTH(32), .MEM_DEPTH(256), .MEM_AW(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_mem_write_enable(in_mem_write_enable), .in_sel_beq_bne(in_sel_beq_bne),
        .in_fl_write_enable(in_fl_write_enable), .in_sel_jt_jf(in_sel_jt_jf),
        .in_sel_jflag_branch(in_sel_jflag_branch), .in_is_branch(in_is_branch),
        .in_is_jump(in_is_jump), .in_wb_res_mux(in_wb_res_mux),
        .in_reg_write_enable(in_reg_write_enable), .in_next_pc(in_next_pc),
        .in_immediate(in_immediate), .in_abs_addr(in_abs_addr),
        .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data), .in_alu_out(in_alu_out),
        .in_alu_flags(in_alu_flags), .in_flag_addr(in_flag_addr), .in_reg_dst(in_reg_dst),
        .branch_taken(branch_taken), .branch_target(branch_target), .flag_reg(flag_reg),
        .wb_reg_write_enable(wb_reg_write_enable), .wb_res_mux(wb_res_mux),
        .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_next_pc(wb_next_pc),
        .wb_immediate(wb_immediate), .wb_reg_dst(wb_reg_dst)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_mem [256];
    bit          m_known [256];
    logic [5:0]  m_flag = 6'd0;
    logic        m_wb_rwe = 1'b0;
    logic [1:0]  m_wb_mux = 2'd0;
    logic [31:0] m_wb_alu = 32'd0, m_wb_mem = 32'd0, m_wb_npc = 32'd0, m_wb_imm = 32'd0;
    logic [4:0]  m_wb_dst = 5'd0;
    bit          m_wb_known = 1'b0;

    typedef struct {
        logic        is_branch, is_jump, bne, jflag, jt, alu0;
        logic [4:0]  faddr;
        logic [31:0] npc, imm, abs_a;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        in_mem_write_enable = 1'b0; in_sel_beq_bne = 1'b0; in_fl_write_enable = 1'b0;
        in_sel_jt_jf = 1'b0; in_sel_jflag_branch = 1'b0; in_is_branch = 1'b0; in_is_jump = 1'b0;
        in_wb_res_mux = 2'd0; in_reg_write_enable = 1'b0;
        in_next_pc = 32'd0; in_immediate = 32'd0; in_abs_addr = 32'd0;
        in_mem_addr = 32'd0; in_mem_data = 32'd0; in_alu_out = 32'd0;
        in_alu_flags = 6'd0; in_flag_addr = 5'd0; in_reg_dst = 5'd0;
    endtask

    // One clock: check redirect, step the model at the edge, check registered state.
    task automatic cycle();
        int   fi;
        int   a;
        logic sel, exp_bt;
        logic [31:0] exp_tg;
        #1;
        fi  = int'(in_flag_addr);
        sel = (fi <= 5) ? m_flag[fi] : 1'b0;
        exp_bt = ((in_is_branch && (in_alu_flags[0] != in_sel_beq_bne)) ||
                  (in_is_jump && (!in_sel_jflag_branch || (sel == in_sel_jt_jf)))) && !flush && !rst;
        exp_tg = in_is_jump ? in_abs_addr : in_next_pc + in_immediate;
        chk("branch_taken", {63'd0, branch_taken}, {63'd0, exp_bt});
        chk("branch_target", {32'd0, branch_target}, {32'd0, exp_tg});
        @(posedge clk);
        if (rst) begin
            m_flag = 6'd0; m_wb_rwe = 1'b0; m_wb_mux = 2'd0; m_wb_alu = 32'd0;
            m_wb_mem = 32'd0; m_wb_npc = 32'd0; m_wb_imm = 32'd0; m_wb_dst = 5'd0;
            m_wb_known = 1'b1;
        end else if (!stall) begin
            a = int'(in_mem_addr % 32'd256);
            m_wb_mem   = m_mem[a];
            m_wb_known = m_known[a];
            if (!flush && in_mem_write_enable) begin
                m_mem[a]   = in_mem_data;
                m_known[a] = 1'b1;
            end
            if (!flush && in_fl_write_enable) m_flag = in_alu_flags;
            m_wb_rwe = in_reg_write_enable && !flush;
            m_wb_mux = in_wb_res_mux; m_wb_alu = in_alu_out; m_wb_npc = in_next_pc;
            m_wb_imm = in_immediate;  m_wb_dst = in_reg_dst;
        end
        #1;
        chk("flag_reg", {58'd0, flag_reg}, {58'd0, m_flag});
        chk("wb_reg_write_enable", {63'd0, wb_reg_write_enable}, {63'd0, m_wb_rwe});
        chk("wb_res_mux", {62'd0, wb_res_mux}, {62'd0, m_wb_mux});
        chk("wb_alu_out", {32'd0, wb_alu_out}, {32'd0, m_wb_alu});
        chk("wb_next_pc", {32'd0, wb_next_pc}, {32'd0, m_wb_npc});
        chk("wb_immediate", {32'd0, wb_immediate}, {32'd0, m_wb_imm});
        chk("wb_reg_dst", {59'd0, wb_reg_dst}, {59'd0, m_wb_dst});
        if (m_wb_known) chk("wb_mem_data", {32'd0, wb_mem_data}, {32'd0, m_wb_mem});
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        idle();
        in_mem_write_enable = 1'b1; in_mem_addr = addr; in_mem_data = data;
        cycle();
    endtask

    task automatic load(input logic [31:0] addr);
        idle();
        in_mem_addr = addr;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset flag_reg", {58'd0, flag_reg}, 64'd0);
        chk("reset wb_rwe", {63'd0, wb_reg_write_enable}, 64'd0);

        // Fill every word, using upper address bits to exercise wrap.
        for (int i = 0; i < 256; i++) begin
            idle();
            in_mem_write_enable = 1'b1;
            in_mem_addr = (32'($urandom_range(0, 255)) << 8) | 32'(i);
            in_mem_data = $urandom;
            in_reg_write_enable = 1'($urandom_range(0, 1));
            cycle();
        end

        // Reset clears flags and WB but not memory; redirect masked during reset.
        store(32'h33, 32'h1234_5678);
        idle();
        in_fl_write_enable = 1'b1; in_alu_flags = 6'h3F; in_reg_write_enable = 1'b1;
        cycle();
        chk("pre-reset flag_reg", {58'd0, flag_reg}, 64'h3F);
        chk("pre-reset wb_rwe", {63'd0, wb_reg_write_enable}, 64'd1);
        idle();
        rst = 1'b1; in_is_jump = 1'b1; in_abs_addr = 32'h99; in_alu_out = 32'h1;
        in_reg_write_enable = 1'b1; in_next_pc = 32'h10;
        #1;
        chk("rst masks branch_taken", {63'd0, branch_taken}, 64'd0);
        cycle();
        chk("post-reset flag_reg", {58'd0, flag_reg}, 64'd0);
        chk("post-reset wb_alu_out", {32'd0, wb_alu_out}, 64'd0);
        chk("post-reset wb_next_pc", {32'd0, wb_next_pc}, 64'd0);
        chk("post-reset wb_rwe", {63'd0, wb_reg_write_enable}, 64'd0);
        load(32'h33);
        chk("mem kept over reset", {32'd0, wb_mem_data}, 64'h1234_5678);

        // Wrapped store/load and read-before-write.
        store(32'h105, 32'hDEAD_BEEF);
        load(32'h005);
        chk("wrap load", {32'd0, wb_mem_data}, 64'hDEAD_BEEF);
        store(32'h10, 32'h1111_1111);
        store(32'h10, 32'h2222_2222);
        chk("read-before-write", {32'd0, wb_mem_data}, 64'h1111_1111);
        load(32'h10);
        chk("load after rbw", {32'd0, wb_mem_data}, 64'h2222_2222);

        // Branch/jump table with flag_reg = 6'b000100.
        idle();
        in_fl_write_enable = 1'b1; in_alu_flags = 6'b000100;
        cycle();
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd100, 32'hFFFF_FFFC, 32'h0,    1'b1, 32'd96};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd100, 32'hFFFF_FFFC, 32'h0,    1'b0, 32'd96};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'd100, 32'hFFFF_FFFC, 32'h40,   1'b1, 32'h40};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'd100, 32'hFFFF_FFFC, 32'h40,   1'b0, 32'h40};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'd100, 32'hFFFF_FFFC, 32'h40,   1'b1, 32'h40};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd100, 32'hFFFF_FFFC, 32'h1234, 1'b1, 32'h1234};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd100, 32'hFFFF_FFFC, 32'h80,   1'b1, 32'h80};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd100, 32'hFFFF_FFFC, 32'h0,    1'b0, 32'd96};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'd100, 32'hFFFF_FFFC, 32'h40,   1'b0, 32'h40};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFE, 32'd4,   32'h0,    1'b1, 32'd2};
        for (int i = 0; i < 10; i++) begin
            idle();
            in_is_branch = tbl[i].is_branch; in_is_jump = tbl[i].is_jump;
            in_sel_beq_bne = tbl[i].bne; in_sel_jflag_branch = tbl[i].jflag;
            in_sel_jt_jf = tbl[i].jt; in_alu_flags = {5'd0, tbl[i].alu0};
            in_flag_addr = tbl[i].faddr; in_next_pc = tbl[i].npc;
            in_immediate = tbl[i].imm; in_abs_addr = tbl[i].abs_a;
            #1;
            chk($sformatf("tbl[%0d] taken", i), {63'd0, branch_taken}, {63'd0, tbl[i].exp_taken});
            chk($sformatf("tbl[%0d] target", i), {32'd0, branch_target}, {32'd0, tbl[i].exp_target});
            cycle();
        end

        // Flush kills store, flag write, reg write and redirect.
        store(32'h20, 32'h0BAD_C0DE);
        idle();
        flush = 1'b1; in_mem_write_enable = 1'b1; in_mem_addr = 32'h20; in_mem_data = 32'hCAFE_F00D;
        in_fl_write_enable = 1'b1; in_alu_flags = 6'h3F; in_reg_write_enable = 1'b1; in_is_jump = 1'b1;
        #1;
        chk("flush branch_taken", {63'd0, branch_taken}, 64'd0);
        cycle();
        chk("flush flag_reg", {58'd0, flag_reg}, 64'h04);
        chk("flush wb_rwe", {63'd0, wb_reg_write_enable}, 64'd0);
        load(32'h20);
        chk("flush no store", {32'd0, wb_mem_data}, 64'h0BAD_C0DE);

        // Stall holds everything for three cycles, then captures on release.
        idle();
        in_mem_write_enable = 1'b1; in_mem_addr = 32'h40; in_mem_data = 32'hA5A5_A5A5; in_alu_out = 32'h55;
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            stall = 1'b1; in_mem_write_enable = 1'b1; in_mem_addr = 32'h40; in_mem_data = 32'hFFFF_0000;
            in_fl_write_enable = 1'b1; in_alu_flags = 6'h2A; in_alu_out = 32'(i + 1);
            in_reg_write_enable = 1'(i); in_reg_dst = 5'(i + 3);
            cycle();
            chk("stall wb_alu_out", {32'd0, wb_alu_out}, 64'h55);
            chk("stall flag_reg", {58'd0, flag_reg}, 64'h04);
        end
        idle();
        in_mem_addr = 32'h40; in_alu_out = 32'h77;
        cycle();
        chk("release wb_alu_out", {32'd0, wb_alu_out}, 64'h77);
        chk("stall no store", {32'd0, wb_mem_data}, 64'hA5A5_A5A5);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            in_mem_write_enable = 1'($urandom); in_sel_beq_bne = 1'($urandom);
            in_fl_write_enable = ($urandom_range(0, 3) == 0); in_sel_jt_jf = 1'($urandom);
            in_sel_jflag_branch = 1'($urandom); in_is_branch = 1'($urandom); in_is_jump = 1'($urandom);
            in_wb_res_mux = 2'($urandom); in_reg_write_enable = 1'($urandom);
            in_next_pc = $urandom; in_immediate = $urandom; in_abs_addr = $urandom;
            in_mem_addr = $urandom; in_mem_data = $urandom; in_alu_out = $urandom;
            in_alu_flags = 6'($urandom);
            in_flag_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            in_reg_dst = 5'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
